// File: rtl/wb_stage_if.sv
// Bundles the result handshake, the register-file write port and the
// forwarding lookup of the write-back stage.
interface wb_stage_if #(
  parameter int DATA_W = 10,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_wb;
  logic              stall;
  logic [NREG-1:0]   reg_wen;
  logic [DATA_W-1:0] reg_d;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;

  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // while in_valid=1 and in_ready=0 the upstream keeps addr/data/wb stable.
  modport master (
    output in_valid, in_addr, in_data, in_wb, stall, lk_addr,
    input  in_ready, reg_wen, reg_d, lk_hit, lk_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_wb, stall, lk_addr,
    output in_ready, reg_wen, reg_d, lk_hit, lk_data
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: FIFO of pending results, one-hot retire port toward the
// 1-bit register cells, and a youngest-wins forwarding lookup.
module wb_stage #(
  parameter int DATA_W   = 10,
  parameter int NREG     = 4,
  parameter int ADDR_W   = 2,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  wb_stage_if.slave              bus,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_wb;
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_not_empty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_head_zero;
  logic              w_lk_zero;
  logic [PTR_W-1:0]  w_idx;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd;
  logic [NREG-1:0]   w_wen;

  assign w_not_empty = (r_count != '0);
  assign w_pop       = w_not_empty && !bus.stall;
  // When full, a slot frees up at the same edge the head pops.
  assign w_ready     = (r_count < CNT_W'(DEPTH)) || !bus.stall;
  assign w_push      = bus.in_valid && w_ready;
  assign w_head_zero = (ZERO_REG != 0) && (r_addr[r_rd_ptr] == '0);
  assign w_lk_zero   = (ZERO_REG != 0) && (bus.lk_addr == '0);

  always_comb begin
    w_wen = '0;
    if (w_pop && r_wb[r_rd_ptr] && !w_head_zero)
      w_wen = NREG'(1) << r_addr[r_rd_ptr];
  end

  // Walk from head (oldest) toward tail so the youngest match overrides.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = r_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (r_vld[w_idx] && r_wb[w_idx] && (r_addr[w_idx] == bus.lk_addr) && !w_lk_zero) begin
        w_hit = 1'b1;
        w_fwd = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_wb     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      // Push after pop so a full-FIFO push into the freed slot stays valid.
      if (w_push) begin
        r_addr[r_wr_ptr] <= bus.in_addr;
        r_data[r_wr_ptr] <= bus.in_data;
        r_wb[r_wr_ptr]   <= bus.in_wb;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.reg_wen  = w_wen;
  assign bus.reg_d    = w_not_empty ? r_data[r_rd_ptr] : '0;
  assign bus.lk_hit   = w_hit;
  assign bus.lk_data  = w_fwd;
  assign o_count      = r_count;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps from the test plan, then random traffic
// checked against a queue model of pending results.
module tb_wb_stage;
  localparam int DATA_W   = 10;
  localparam int NREG     = 4;
  localparam int ADDR_W   = 2;
  localparam int DEPTH    = 2;
  localparam int ZERO_REG = 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] count;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model entry: {addr[12:11], data[10:1], wb[0]}, oldest at index 0.
  logic [12:0] exp_q[$];
  logic        last_blocked = 1'b0;

  wb_stage_if #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) bus ();

  wb_stage #(
    .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave),
    .o_count (count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: called at posedge+1, leaves inputs settled at posedge+4.
  task automatic drive(input logic v, input logic [1:0] a, input logic [9:0] d,
                       input logic wb, input logic st, input logic [1:0] la);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_wb    = wb;
    bus.stall    = st;
    bus.lk_addr  = la;
    #3;
  endtask

  // Scoreboard: derive every output from the list of pending results.
  task automatic model_check();
    int          n;
    logic [3:0]  e_wen;
    logic [9:0]  e_d;
    logic        e_hit;
    logic [9:0]  e_fwd;
    logic [12:0] h;
    n     = exp_q.size();
    e_wen = 4'b0;
    e_d   = 10'h0;
    e_hit = 1'b0;
    e_fwd = 10'h0;
    if (n > 0) begin
      h   = exp_q[0];
      e_d = h[10:1];
      if (!bus.stall && h[0] && !(ZERO_REG == 1 && h[12:11] == 2'd0))
        e_wen = 4'b0001 << h[12:11];
    end
    for (int i = 0; i < n; i++) begin
      h = exp_q[i];
      if (h[0] && h[12:11] == bus.lk_addr && !(ZERO_REG == 1 && bus.lk_addr == 2'd0)) begin
        e_hit = 1'b1;
        e_fwd = h[10:1];
      end
    end
    chk("count",    32'(count),        32'(n));
    chk("in_ready", 32'(bus.in_ready), 32'((n < DEPTH) || !bus.stall));
    chk("reg_wen",  32'(bus.reg_wen),  32'(e_wen));
    chk("reg_d",    32'(bus.reg_d),    32'(e_d));
    chk("lk_hit",   32'(bus.lk_hit),   32'(e_hit));
    chk("lk_data",  32'(bus.lk_data),  32'(e_fwd));
    chk("count_max", 32'(count <= 2'(DEPTH)), 32'd1);
  endtask

  // Advance one edge and apply the same transfer to the model.
  task automatic edge_step();
    logic push;
    logic pop;
    push = bus.in_valid && ((exp_q.size() < DEPTH) || !bus.stall);
    pop  = (exp_q.size() > 0) && !bus.stall;
    last_blocked = bus.in_valid && !push;
    @(posedge clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back({bus.in_addr, bus.in_data, bus.in_wb});
    #1;
  endtask

  task automatic cyc(input logic v, input logic [1:0] a, input logic [9:0] d,
                     input logic wb, input logic st, input logic [1:0] la);
    drive(v, a, d, wb, st, la);
    model_check();
    edge_step();
  endtask

  // Mid-cycle reset: outputs must clear with no clock edge in between.
  task automatic mid_reset();
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count",   32'(count),       32'd0);
    chk("rst_reg_wen", 32'(bus.reg_wen), 32'd0);
    chk("rst_reg_d",   32'(bus.reg_d),   32'd0);
    chk("rst_lk_hit",  32'(bus.lk_hit),  32'd0);
    chk("rst_lk_data", 32'(bus.lk_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    chk("rst_no_wen_at_edge", 32'(bus.reg_wen), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       v;
    logic [1:0] a;
    logic [9:0] d;
    logic       wb;
    logic       st;
    logic [1:0] la;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.in_wb    = 1'b0;
    bus.stall    = 1'b0;
    bus.lk_addr  = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    cyc(0, 0, 0, 0, 0, 0);

    // Single result, one-cycle latency into the register cell
    cyc(1, 2, 10'h155, 1, 0, 2);
    drive(0, 0, 0, 0, 0, 2);
    model_check();
    chk("t1_wen",   32'(bus.reg_wen), 32'b0100);
    chk("t1_d",     32'(bus.reg_d),   32'h155);
    chk("t1_count", 32'(count),       32'd1);
    edge_step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_empty", 32'(count), 32'd0);
    edge_step();
    // Reset while a write is being presented
    cyc(1, 1, 10'h0F0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("t1_pre_rst_wen", 32'(bus.reg_wen), 32'b0010);
    mid_reset();

    // Back-to-back pushes under stall, then release
    cyc(1, 1, 10'h011, 1, 1, 0);
    cyc(1, 2, 10'h022, 1, 1, 0);
    drive(1, 3, 10'h033, 1, 1, 0);
    model_check();
    chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_full_count", 32'(count),        32'd2);
    edge_step();
    drive(1, 3, 10'h033, 1, 0, 0);
    model_check();
    chk("t2_ret1",       32'(bus.reg_d),    32'h011);
    chk("t2_ready_pop",  32'(bus.in_ready), 32'd1);
    edge_step();
    drive(0, 0, 0, 0, 0, 0);
    model_check();
    chk("t2_ret2", 32'(bus.reg_d), 32'h022);
    edge_step();
    drive(0, 0, 0, 0, 0, 0);
    model_check();
    chk("t2_ret3",     32'(bus.reg_d),   32'h033);
    chk("t2_ret3_wen", 32'(bus.reg_wen), 32'b1000);
    edge_step();

    // Forwarding picks the youngest pending write
    cyc(1, 1, 10'h00A, 1, 1, 1);
    cyc(1, 1, 10'h3FF, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    model_check();
    chk("t3_hit1",  32'(bus.lk_hit),  32'd1);
    chk("t3_data1", 32'(bus.lk_data), 32'h3FF);
    drive(0, 0, 0, 0, 1, 3);
    model_check();
    chk("t3_hit3",  32'(bus.lk_hit),  32'd0);
    edge_step();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // No-write entry and register-0 entry
    cyc(1, 3, 10'h111, 0, 0, 3);
    drive(0, 0, 0, 0, 0, 3);
    model_check();
    chk("t4_nowb_wen", 32'(bus.reg_wen), 32'd0);
    chk("t4_nowb_hit", 32'(bus.lk_hit),  32'd0);
    edge_step();
    cyc(1, 0, 10'h2AA, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    model_check();
    chk("t4_r0_wen", 32'(bus.reg_wen), 32'd0);
    chk("t4_r0_d",   32'(bus.reg_d),   32'h2AA);
    chk("t4_r0_hit", 32'(bus.lk_hit),  32'd0);
    edge_step();

    // Reset with the FIFO full, then normal operation resumes
    cyc(1, 2, 10'h0AB, 1, 1, 2);
    cyc(1, 3, 10'h0CD, 1, 1, 2);
    drive(0, 0, 0, 0, 1, 2);
    chk("t5_full", 32'(count), 32'd2);
    mid_reset();
    cyc(0, 0, 0, 0, 0, 2);
    cyc(1, 1, 10'h123, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    model_check();
    chk("t5_after_wen", 32'(bus.reg_wen), 32'b0010);
    chk("t5_after_d",   32'(bus.reg_d),   32'h123);
    edge_step();

    // Random traffic; a blocked push holds its payload until accepted
    v = 0; a = 0; d = 0; wb = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!last_blocked) begin
        v  = 1'($urandom_range(0, 1));
        a  = 2'($urandom_range(0, 3));
        d  = 10'($urandom_range(0, 1023));
        wb = ($urandom_range(0, 3) != 0);
      end
      st = ($urandom_range(0, 2) == 0);
      la = 2'($urandom_range(0, 3));
      cyc(v, a, d, wb, st, la);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 10-bit computer. Sits between execute/memory and the register file built from 1-bit register cells.
- Accepts results over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Retires one entry per cycle as a one-hot per-register write enable plus a data bus.
- Exposes a forwarding lookup so decode can read results that are still pending.

Parameters:
- DATA_W, 10, width of result data.
- NREG, 4, number of architectural registers.
- ADDR_W, 2, register address width; equals log2(NREG).
- DEPTH, 2, number of FIFO entries (power of two, at least 2).
- ZERO_REG, 1, if 1, writes to register 0 are retired but suppressed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; asserted while 0.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept this cycle.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  result value.
- in_wb  in  1  1 = entry writes a register; 0 = retire with no write (store/branch).
- stall  in  1  register file write blocked this cycle.
- reg_wen  out  NREG  one-hot write enable to the register cells.
- reg_d  out  DATA_W  write data to the register cells.
- lk_addr  in  ADDR_W  forwarding lookup address.
- lk_hit  out  1  a pending write to lk_addr exists.
- lk_data  out  DATA_W  data of the youngest pending write to lk_addr.
- count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0; read and write pointers = 0; all entry valid bits = 0.
  - Outputs: reg_wen=0, reg_d=0, lk_hit=0, lk_data=0.
  - in_ready=1 once rst=1.
  - Reset mid-operation discards all pending entries; none are retired.
- Push:
  - Occurs when in_valid && in_ready. {addr, data, wb} is written at the tail on the rising edge.
  - While in_valid=1 and in_ready=0, upstream holds its inputs stable.
- Pop:
  - pop = (count>0) && !stall. Head is removed on the rising edge.
- Retire outputs (combinational from the head; no output registers):
  - When pop and head.wb=1: reg_wen = onehot(head.addr), reg_d = head.data.
  - reg_wen=0 when any of the following holds:
    - count=0
    - stall=1
    - head.wb=0
    - ZERO_REG=1 and head.addr=0
  - reg_d = head.data whenever count>0, else 0.
  - The register cell captures at the same edge the entry pops.
- Latency: a result pushed at edge N, into an empty stage with stall=0, is written into the register at edge N+1.
- Flow control:
  - in_ready = (count<DEPTH) || (count==DEPTH && !stall).
  - When full, push and pop in the same cycle are allowed; count is unchanged.
- Count update: push only +1; pop only -1; both or neither, unchanged. Pointers wrap modulo DEPTH.
- Empty: stall has no effect. No pop and no underflow occur.
- Forwarding (combinational):
  - Scan all occupied entries with wb=1 whose addr equals lk_addr; the youngest (closest to tail) wins.
  - lk_hit=1 and lk_data = that entry's data; otherwise lk_hit=0, lk_data=0.
  - The entry being popped this cycle still counts as pending.
  - The entry being pushed this cycle is not visible until the next cycle.
  - With ZERO_REG=1, lk_addr=0 never hits.
- Ordering: strict FIFO; retire order equals accept order.

Test Plan:
- Reset, then push {addr=2, data=10'h155, wb=1} at edge 1 with stall=0:
  - During cycle 1, reg_wen=4'b0100 and reg_d=10'h155.
  - count returns to 0 after edge 2.
  - Assert rst=0 mid-cycle: outputs go to 0 immediately, without waiting for a clock edge.
- Hold stall=1 and push three results back-to-back:
  - Pushes are accepted at edges 1 and 2; in_ready=0 on the third; count=2.
  - Release stall: retire order is first, second, third, one per cycle; the third is accepted at the same edge the first pops.
- Forwarding with stall=1:
  - Push {1, 10'h00A} then {1, 10'h3FF}; lookup lk_addr=1 -> lk_hit=1, lk_data=10'h3FF.
  - Lookup lk_addr=3 -> lk_hit=0.
- No-write and zero-register entries:
  - Push {addr=3, wb=0}: the entry pops, reg_wen stays 0, and lk_addr=3 does not hit.
  - Push {addr=0, data=10'h2AA, wb=1} with ZERO_REG=1: reg_wen stays 0.
- Reset mid-operation:
  - Fill to count=2 with stall=1, then pulse rst=0.
  - count=0, no reg_wen pulse, lk_hit=0.
  - A new push after reset retires normally.
- Random stress of 1000 cycles with random in_valid, stall and addresses against a reference queue model:
  - Write stream exactly matches the model.
  - count is never above DEPTH.
